// File: rtl/seq_logger_pkg.sv
// Shared constants and helpers for the sequence event logger.
// Sizes here are the defaults; instances may override DEPTH and TS_WIDTH.
package seq_logger_pkg;

  localparam int DEPTH_DEFAULT    = 4;
  localparam int TS_WIDTH_DEFAULT = 16;
  localparam int COUNT_WIDTH      = 8;

  typedef logic [COUNT_WIDTH-1:0] count_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic count_t sat_inc(input count_t value);
    return (value == '1) ? value : value + count_t'(1);
  endfunction

endpackage

// File: rtl/sequence_event_logger_if.sv
// Valid/ready event stream from the logger FIFO head to its consumer.
// The logger drives through master; the consumer uses slave.
interface sequence_event_logger_if
  import seq_logger_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEFAULT
) ();

  logic                evt_valid;
  logic                evt_ready;
  logic [TS_WIDTH-1:0] evt_timestamp;

  modport master (output evt_valid, output evt_timestamp, input evt_ready);
  modport slave  (input evt_valid, input evt_timestamp, output evt_ready);

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; wrap-bit pointers give full/empty.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Show zero when empty so the head output is defined straight out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are meaningful, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sequence_event_logger.sv
// Timestamps rising edges of sequence_found into a FWFT FIFO, counts every
// event (saturating) and flags any event lost to a full FIFO.
module sequence_event_logger
  import seq_logger_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int TS_WIDTH = TS_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sequence_found,
  input  logic                           clear,
  sequence_event_logger_if.master        evt,
  output logic [COUNT_WIDTH-1:0]         match_count,
  output logic                           overflow
);

  logic                sync_rst;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic                found_q;
  logic                event_hit;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [TS_WIDTH-1:0] head_ts;

  // Clear is indistinguishable from reset, so both feed one synchronous reset.
  assign sync_rst  = reset || clear;
  assign event_hit = sequence_found && !found_q;
  assign pop       = evt.evt_valid && evt.evt_ready;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      ts_cnt      <= '0;
      found_q     <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      ts_cnt  <= ts_cnt + TS_WIDTH'(1);
      found_q <= sequence_found;
      if (event_hit) begin
        match_count <= sat_inc(match_count);
        // A full FIFO only makes room when the head is consumed this same edge.
        if (fifo_full && !pop) overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (sync_rst),
    .push  (event_hit),
    .pop   (pop),
    .wdata (ts_cnt),
    .rdata (head_ts),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt.evt_valid     = !fifo_empty;
  assign evt.evt_timestamp = head_ts;

endmodule

// File: tb/tb_sequence_event_logger.sv
// Drives a 16-bit and a 4-bit timestamp logger with shared stimulus and
// compares both against a queue-based model of the logging rules.
module tb_sequence_event_logger;
  import seq_logger_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic sequence_found = 1'b0;
  logic evt_ready = 1'b0;

  logic [COUNT_WIDTH-1:0] count16, count4;
  logic                   ovf16, ovf4;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_ts;
  bit          m_prev;
  logic [15:0] m_q[$];
  int          m_cnt;
  bit          m_ovf;

  always #5 clk = ~clk;

  sequence_event_logger_if #(.TS_WIDTH(16)) if16 ();
  sequence_event_logger_if #(.TS_WIDTH(4))  if4 ();

  assign if16.evt_ready = evt_ready;
  assign if4.evt_ready  = evt_ready;

  sequence_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(16)) dut16 (
    .clk            (clk),
    .reset          (reset),
    .sequence_found (sequence_found),
    .clear          (clear),
    .evt            (if16),
    .match_count    (count16),
    .overflow       (ovf16)
  );

  sequence_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .sequence_found (sequence_found),
    .clear          (clear),
    .evt            (if4),
    .match_count    (count4),
    .overflow       (ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies the logging rules for one rising edge given the sampled inputs.
  task automatic model_edge(input bit sf, input bit rdy, input bit clr, input bit rst);
    bit ev, do_pop, room;
    if (rst || clr) begin
      m_ts = 0; m_prev = 0; m_q.delete(); m_cnt = 0; m_ovf = 0;
    end else begin
      ev     = sf && !m_prev;
      do_pop = (m_q.size() != 0) && rdy;
      room   = (m_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(m_q.pop_front());
      if (ev) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (room) m_q.push_back(16'(m_ts));
        else m_ovf = 1;
      end
      m_prev = sf;
      m_ts   = (m_ts + 1) % 65536;
    end
  endtask

  task automatic compare_all();
    logic [15:0] head;
    check("valid16", 32'(if16.evt_valid), 32'(m_q.size() != 0));
    check("valid4",  32'(if4.evt_valid),  32'(m_q.size() != 0));
    check("count16", 32'(count16), 32'(m_cnt));
    check("count4",  32'(count4),  32'(m_cnt));
    check("ovf16",   32'(ovf16), 32'(m_ovf));
    check("ovf4",    32'(ovf4),  32'(m_ovf));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check("ts16", 32'(if16.evt_timestamp), 32'(head));
      check("ts4",  32'(if4.evt_timestamp),  32'(head[3:0]));
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, compare at negedge.
  task automatic cycle(input bit sf, input bit rdy, input bit clr = 0, input bit rst = 0);
    sequence_found = sf;
    evt_ready      = rdy;
    clear          = clr;
    reset          = rst;
    @(posedge clk);
    model_edge(sf, rdy, clr, rst);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy = 0);
    for (int i = 0; i < n; i++) cycle(0, rdy);
  endtask

  initial begin
    @(negedge clk);

    // Reset state; the cycle after this is cycle 0.
    cycle(0, 0, 0, 1);
    check("rst_valid", 32'(if16.evt_valid), 0);
    check("rst_ts",    32'(if16.evt_timestamp), 0);
    check("rst_cnt",   32'(count16), 0);
    check("rst_ovf",   32'(ovf16), 0);

    // Single event in cycle 5.
    idle(5);
    cycle(1, 0);
    check("single_valid", 32'(if16.evt_valid), 1);
    check("single_ts",    32'(if16.evt_timestamp), 5);
    check("single_cnt",   32'(count16), 1);
    cycle(0, 1);
    check("single_popped", 32'(if16.evt_valid), 0);

    // Held level, cycles 3..10.
    cycle(0, 0, 0, 1);
    idle(3);
    for (int c = 3; c <= 10; c++) cycle(1, 0);
    cycle(0, 0);
    check("held_cnt", 32'(count16), 1);
    check("held_ts",  32'(if16.evt_timestamp), 3);
    cycle(0, 1);
    check("held_one_entry", 32'(if16.evt_valid), 0);

    // Overflow: pulses at 2,4,6,8,10 with no consumer.
    cycle(0, 0, 0, 1);
    for (int c = 0; c <= 10; c++) cycle(c >= 2 && c % 2 == 0, 0);
    check("ovf_flag", 32'(ovf16), 1);
    check("ovf_cnt",  32'(count16), 5);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain", 32'(if16.evt_timestamp), 32'(2 + 2 * i));
      cycle(0, 1);
    end
    check("ovf_empty", 32'(if16.evt_valid), 0);

    // Full FIFO with a same-cycle pop at cycle 12.
    cycle(0, 0, 0, 1);
    for (int c = 0; c <= 11; c++) cycle(c >= 2 && c <= 8 && c % 2 == 0, 0);
    cycle(1, 1);
    check("fullpop_ovf", 32'(ovf16), 0);
    check("fullpop_cnt", 32'(count16), 5);
    for (int i = 0; i < 4; i++) begin
      check("fullpop_drain", 32'(if16.evt_timestamp), (i < 3) ? 32'(4 + 2 * i) : 32'd12);
      cycle(0, 1);
    end

    // 4-bit timestamp wrap: events at ts 15 and 1.
    cycle(0, 0, 0, 1);
    idle(15);
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 0);
    check("wrap_first", 32'(if4.evt_timestamp), 15);
    cycle(0, 1);
    check("wrap_second", 32'(if4.evt_timestamp), 1);
    cycle(0, 1);

    // Saturation after 300 events.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      cycle(1, 1);
      cycle(0, 1);
    end
    check("sat_cnt16", 32'(count16), 255);
    check("sat_cnt4",  32'(count4), 255);

    // Clear and reset mid-operation, with three entries queued.
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
        cycle(0, 0);
        cycle(1, 0);
      end
      check("mid_queued_cnt", 32'(count16), 3);
      if (k == 0) cycle(1, 0, 1, 0);
      else        cycle(1, 0, 0, 1);
      check("mid_valid", 32'(if16.evt_valid), 0);
      check("mid_cnt",   32'(count16), 0);
      check("mid_ovf",   32'(ovf16), 0);
      cycle(1, 0);
      check("mid_ts_restart", 32'(if16.evt_timestamp), 0);
    end

    // Randomized traffic with occasional clear/reset.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 249) == 0, $urandom_range(0, 399) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_event_logger.md
SEQUENCE_EVENT_LOGGER -- requirements
Module: sequence_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TS_WIDTH, default 16, meaning timestamp width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sequence_found  input  1  match flag from the upstream sequence detector.
REQ-006 SHALL have port clear  input  1  synchronous clear of counters, FIFO and flags.
REQ-007 SHALL have port evt_valid  output  1  the FIFO head entry is valid.
REQ-008 SHALL have port evt_ready  input  1  the consumer accepts the head entry.
REQ-009 SHALL have port evt_timestamp  output  TS_WIDTH  the timestamp of the head entry.
REQ-010 SHALL have port match_count  output  8  the number of accepted and dropped events, saturating.
REQ-011 SHALL have port overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-012 SHALL run free-running counter ts_cnt (TS_WIDTH bits): 0 in the cycle after reset or clear, +1 every cycle, wrapping from all-ones to 0.
REQ-013 SHALL register sequence_found each cycle; event = sequence_found==1 and the registered previous value==0 (rising edge only; a held-high level counts once).
REQ-014 SHALL push ts_cnt as sampled at the event edge into the FIFO.
REQ-015 SHALL make the pushed entry visible at the outputs one cycle after the event edge.
REQ-016 SHALL operate the FIFO as first-word fall-through: evt_valid=1 iff the FIFO is non-empty, and evt_timestamp = oldest entry.
REQ-017 SHALL pop only on a cycle with evt_valid=1 and evt_ready=1; evt_ready is ignored when the FIFO is empty.
REQ-018 SHALL hold evt_timestamp stable while evt_valid=1 and evt_ready=0.
REQ-019 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle; the occupancy is then unchanged.
REQ-020 SHALL handle simultaneous push and pop on an empty FIFO as a push only: no pop, the entry is visible next cycle.
REQ-021 SHALL drop an event when the FIFO is full and no same-cycle pop occurs; the FIFO contents stay unchanged and overflow is set to 1.
REQ-022 SHALL increment match_count on every event (accepted or dropped), saturating at 255.
REQ-023 SHALL use read/write pointers of log2(DEPTH) bits plus a wrap bit; full/empty come from the pointer compare.
REQ-024 SHALL make clear=1 behave identically to reset, applied on the same edge, including discarding an event on that edge.

Reset
REQ-025 SHALL on reset=1 at a rising edge set: ts_cnt=0, previous-sample register=0, FIFO empty, evt_valid=0, evt_timestamp=0, match_count=0, overflow=0.
REQ-026 SHALL give reset priority over clear, events and pops in the same cycle; reset mid-operation discards all entries.
REQ-027 SHALL not require sequence_found to be low when reset releases; a high level in the first cycle after reset counts as an event.

Structure
REQ-028 SHALL place DEPTH_DEFAULT, TS_WIDTH_DEFAULT and COUNT_WIDTH=8 in the shared package seq_logger_pkg.
REQ-029 SHALL implement the FIFO as one sub-module, sync_fifo (parameterised width/depth, FWFT, with push/pop/full/empty); edge detect, timestamp counter and match counter live in the top level.

Verification
REQ-030 SHALL cover the single-event case: release reset at cycle 0, pulse sequence_found in cycle 5 -> evt_valid in cycle 6 with evt_timestamp=5, match_count=1; evt_ready=1 -> evt_valid=0 next cycle.
REQ-031 SHALL cover a held level: sequence_found high for cycles 3..10 -> exactly one entry (timestamp 3), match_count=1.
REQ-032 SHALL cover overflow: evt_ready=0, pulses in cycles 2,4,6,8,10 -> 4 entries 2,4,6,8, the event at 10 dropped, overflow=1, match_count=5; drain returns 2,4,6,8 in order.
REQ-033 SHALL cover full with simultaneous pop: FIFO full with 2,4,6,8, pulse in cycle 12 with evt_ready=1 -> 2 popped and 12 accepted, overflow stays 0, drain returns 4,6,8,12.
REQ-034 SHALL cover wrap and saturation: TS_WIDTH=4, event at ts_cnt=15 and next at 1 -> timestamps 15, 1; 300 events -> match_count=255.
REQ-035 SHALL cover reset/clear mid-operation: 3 entries queued, then clear=1 for one cycle -> evt_valid=0, match_count=0, overflow=0, ts_cnt restarts at 0; the same with reset gives the identical result.
